// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer.
package pc_seq_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux: sequential step or word-aligned redirect, plus misalignment flag.
module pc_next_sel
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc_next,
  output logic        misaligned
);
  always_comb begin
    pc_next    = pc + PC_STEP;
    misaligned = 1'b0;
    if (redirect_valid) begin
      pc_next    = redirect_target & ALIGN_MASK;
      misaligned = |redirect_target[1:0];
    end
  end
endmodule

// File: rtl/pc_fetch_sequencer.sv
// Owns the PC, fetches one instruction per PC from imem and issues it to decode.
// A watchdog traps a hung imem into a sticky ERROR state.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc_out,
  output logic [31:0] retired,
  output logic        err
);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] retired_q, retired_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic        err_q, err_d;

  logic [31:0] pc_next;
  logic        misaligned;

  pc_next_sel u_next_sel (
    .pc              (pc_q),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc_next         (pc_next),
    .misaligned      (misaligned)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    retired_d     = retired_q;
    wdog_d        = wdog_q;
    imem_req_d    = imem_req_q;
    instr_valid_d = instr_valid_q;
    err_d         = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d    = ST_FETCH;
          imem_req_d = 1'b1;
        end
      end
      ST_FETCH: begin
        // An ack on the final watchdog cycle still wins over the timeout.
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_pc_d    = pc_q;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b1;
          wdog_d        = 8'd0;
          state_d       = ST_ISSUE;
        end else if (wdog_q == WD_LAST) begin
          imem_req_d = 1'b0;
          err_d      = 1'b1;
          wdog_d     = wdog_q + 8'd1;
          state_d    = ST_ERROR;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          retired_d     = retired_q + 32'd1;
          pc_d          = pc_next;
          err_d         = err_q | misaligned;
          instr_valid_d = 1'b0;
          if (run) begin
            state_d    = ST_FETCH;
            imem_req_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ERROR: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_VEC;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      retired_q     <= 32'd0;
      wdog_q        <= 8'd0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      retired_q     <= retired_d;
      wdog_q        <= wdog_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      err_q         <= err_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_out      = pc_q;
  assign retired     = retired_q;
  assign err         = err_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: acts as imem and decode, tracks a transaction-level model.
module tb_pc_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst, run, imem_req, imem_ack, instr_valid, instr_ready;
  logic        redirect_valid, err;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_target, pc_out, retired;

  pc_fetch_sequencer #(.RESET_VEC(32'h0), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .pc_out(pc_out), .retired(retired), .err(err)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;

  // Model state: PC of the next fetch, retired count, sticky error.
  logic [31:0] m_pc, m_ret;
  logic        m_err;

  typedef struct {
    int          ack_dly;
    int          rdy_dly;
    bit          rv;
    logic [31:0] tgt;
    bit          run_after;
    logic [31:0] exp_pc;
    bit          exp_err;
  } vec_t;
  vec_t tbl[10];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'd0; imem_rdata = 32'd0;
    tick; tick;
    rst = 1'b0;
    m_pc = 32'h0; m_ret = 32'd0; m_err = 1'b0;
  endtask

  task automatic wait_req;
    int n;
    n = 0;
    while (!imem_req && n < 40) begin
      tick;
      n++;
    end
    chk("req_wait", {31'd0, imem_req}, 32'd1);
  endtask

  // One full fetch/issue transaction; the model advances on the handshake.
  task automatic txn(input int ack_dly, input int rdy_dly, input bit rv,
                     input logic [31:0] tgt, input bit run_after);
    logic [31:0] d;
    run = 1'b1;
    wait_req;
    chk("imem_addr", imem_addr, m_pc);
    for (int i = 0; i < ack_dly; i++) begin
      imem_rdata = $urandom;
      tick;
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, m_pc);
    end
    d = $urandom;
    imem_ack = 1'b1; imem_rdata = d;
    tick;
    imem_ack = 1'b0;
    chk("instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("instr", instr, d);
    chk("instr_pc", instr_pc, m_pc);
    chk("req_drop", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      redirect_valid = $urandom_range(0, 1);
      redirect_target = $urandom;
      tick;
      chk("stall_instr", instr, d);
      chk("stall_instr_pc", instr_pc, m_pc);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_no_req", {31'd0, imem_req}, 32'd0);
      chk("stall_pc", pc_out, m_pc);
    end
    instr_ready = 1'b1; redirect_valid = rv; redirect_target = tgt; run = run_after;
    tick;
    instr_ready = 1'b0; redirect_valid = 1'b0;
    m_ret = m_ret + 32'd1;
    if (rv) begin
      m_pc = tgt - (tgt % 4);
      if (tgt % 4 != 0) m_err = 1'b1;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    chk("retired", retired, m_ret);
    chk("pc_out", pc_out, m_pc);
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("valid_clr", {31'd0, instr_valid}, 32'd0);
    if (!run_after) begin
      repeat (3) tick;
      chk("idle_no_req", {31'd0, imem_req}, 32'd0);
      chk("idle_pc", pc_out, m_pc);
      run = 1'b1;
    end
  endtask

  initial begin
    tbl[0] = '{0, 0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0};
    tbl[1] = '{0, 0, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b0};
    tbl[2] = '{0, 0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b0};
    tbl[3] = '{2, 5, 1'b0, 32'h0,         1'b0, 32'h0000_0010, 1'b0};
    tbl[4] = '{15, 0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0};
    tbl[5] = '{1, 1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0};
    tbl[6] = '{0, 0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0};
    tbl[7] = '{0, 2, 1'b1, 32'h0000_0102, 1'b1, 32'h0000_0100, 1'b1};
    tbl[8] = '{3, 0, 1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b1};
    tbl[9] = '{0, 3, 1'b1, 32'h0000_0203, 1'b1, 32'h0000_0200, 1'b1};

    do_reset;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    tick; tick;
    chk("idle_hold", {31'd0, imem_req}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      txn(tbl[i].ack_dly, tbl[i].rdy_dly, tbl[i].rv, tbl[i].tgt, tbl[i].run_after);
      chk("tbl_pc", pc_out, tbl[i].exp_pc);
      chk("tbl_err", {31'd0, err}, {31'd0, tbl[i].exp_err});
      chk("tbl_retired", retired, 32'(i + 1));
    end

    // Watchdog: no ack ever arrives.
    do_reset;
    run = 1'b1;
    wait_req;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (i == 14) begin
        chk("wd_req_before", {31'd0, imem_req}, 32'd1);
        chk("wd_err_before", {31'd0, err}, 32'd0);
      end
    end
    tick;
    chk("wd_err", {31'd0, err}, 32'd1);
    chk("wd_req_off", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      imem_ack = $urandom_range(0, 1); instr_ready = 1'b1;
      tick;
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
    chk("err_sticky", {31'd0, err}, 32'd1);
    chk("err_no_req", {31'd0, imem_req}, 32'd0);
    chk("err_no_valid", {31'd0, instr_valid}, 32'd0);
    chk("err_pc_frozen", pc_out, 32'h0);
    chk("err_retired", retired, 32'd0);

    // Reset in FETCH with a simultaneous ack: the ack is dropped.
    do_reset;
    txn(0, 0, 1'b0, 32'h0, 1'b1);
    wait_req;
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; run = 1'b0;
    tick;
    rst = 1'b0; imem_ack = 1'b0;
    chk("rfetch_pc", pc_out, 32'h0);
    chk("rfetch_valid", {31'd0, instr_valid}, 32'd0);
    chk("rfetch_retired", retired, 32'd0);
    chk("rfetch_req", {31'd0, imem_req}, 32'd0);
    tick; tick;
    chk("rfetch_idle", {31'd0, imem_req}, 32'd0);
    chk("rfetch_instr", instr, 32'd0);

    // Randomized transactions against the model.
    do_reset;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 7) != 0) t = t - (t % 4);
      txn($urandom_range(0, 15), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
          t, ($urandom_range(0, 4) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: sim still running at %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the program-counter register and sequences instruction fetch for the 32-bit MIPS core.
- Issues one imem request per PC and waits for the memory ack.
- Hands the instruction to decode through a valid/ready handshake.
- Selects the next PC: sequential (+4) or a redirect supplied by branch/jump resolution.
- A watchdog traps a hung instruction memory in a sticky error state.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max cycles FETCH waits for imem_ack before error (range 2..255).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- run  input  1  1 = fetch enabled; 0 = hold in IDLE
- imem_req  output  1  fetch request, held high until ack
- imem_addr  output  32  fetch address (= pc_out while imem_req)
- imem_ack  input  1  read data valid this cycle
- imem_rdata  input  32  instruction word
- instr_valid  output  1  instr/instr_pc valid to decode
- instr_ready  input  1  decode accepts instruction
- instr  output  32  captured instruction
- instr_pc  output  32  PC of instr
- redirect_valid  input  1  take redirect_target as next PC (sampled on issue handshake only)
- redirect_target  input  32  branch/jump/jr target
- pc_out  output  32  current PC register
- retired  output  32  count of accepted instructions
- err  output  1  sticky: imem timeout or misaligned redirect

Behaviour:
- One clock domain (clk); synchronous active-high reset (rst); all state updates on rising clk edge.
- Reset values: pc_out=RESET_VEC, imem_req=0, imem_addr=RESET_VEC, instr_valid=0, instr=0, instr_pc=0, retired=0, err=0, state=IDLE, watchdog=0.
- rst asserted mid-operation aborts any fetch or issue next edge; an in-flight imem_ack arriving after reset is ignored.
- States: IDLE, FETCH, ISSUE, ERROR.
- IDLE:
  - run=1 -> FETCH; imem_req=1 is registered, so it is visible the cycle after the run sample.
  - run=0 -> stay.
- FETCH:
  - imem_req=1, imem_addr=pc_out; watchdog increments each cycle without ack.
  - imem_ack=1 -> instr<=imem_rdata, instr_pc<=pc_out, imem_req<=0, instr_valid<=1, watchdog<=0 -> ISSUE.
  - Minimum latency from entering FETCH to instr_valid: 1 cycle after ack.
  - Watchdog reaches TIMEOUT with no ack -> imem_req<=0, err<=1 -> ERROR.
  - An ack in the same cycle the watchdog hits TIMEOUT counts as success.
- ISSUE:
  - instr_valid=1; instr and instr_pc are stable until the handshake.
  - Handshake = instr_valid & instr_ready. On handshake:
    - retired<=retired+1, wrapping modulo 2^32.
    - pc_out<=redirect_valid ? {redirect_target[31:2],2'b00} : pc_out+4, modulo 2^32 (0xFFFF_FFFC+4 -> 0).
    - instr_valid<=0.
    - Then -> FETCH if run=1, else IDLE.
  - redirect_valid with redirect_target[1:0]!=0 -> aligned target still loaded, err<=1, but sequencing continues (no ERROR state).
  - redirect_valid without a handshake is ignored.
  - run deasserted while in FETCH or ISSUE does not abort; it takes effect at the next PC update.
- ERROR:
  - imem_req=0, instr_valid=0, pc_out frozen; exits only on rst.
- err is sticky in all states; cleared only by rst.

Decomposition:
- Shared package pc_seq_pkg:
  - state enum (IDLE, FETCH, ISSUE, ERROR);
  - PC_STEP=32'd4;
  - ALIGN_MASK=32'hFFFF_FFFC.
- One natural sub-module: pc_next_sel. Combinational mux producing the next PC (pc+4 vs aligned redirect) plus the misalignment flag.
- The existing PC register is absorbed into this block; no separate instance.

Test Plan:
- Reset then run=1, imem_ack one cycle after each req, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; retired=3 after third handshake; err=0.
- Hold instr_ready=0 for 5 cycles in ISSUE -> instr/instr_pc constant, no new imem_req, pc_out unchanged; release -> pc_out=+4.
- redirect_valid=1, target=0x0000_0100 on handshake -> next imem_addr=0x100. Target 0x0000_0102 -> imem_addr=0x100, err=1, fetching continues.
- TIMEOUT=16, no imem_ack -> err=1 exactly at the 16th wait cycle, imem_req=0, stays ERROR until rst; an ack at wait 16 instead -> ISSUE, err=0.
- PC=0xFFFF_FFFC with sequential handshake -> pc_out=0x0; retired preloaded to 0xFFFF_FFFF wraps to 0.
- rst asserted in FETCH with an ack arriving the same cycle -> next cycle pc_out=RESET_VEC, instr_valid=0, retired=0, state IDLE.
